// File: rtl/k423_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : k423_if_pkg
// Description : Shared constants and the fetch-entry type for instruction fetch.
// Revision    : 1.0 - initial release
// ============================================================================
package k423_if_pkg;

    localparam int          INST_BYTES   = 4;
    localparam int          FETCH_QDEPTH = 2;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Two-entry FIFO for fetched instructions; flush beats push.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import k423_if_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [1:0]       o_count,
    output logic [WIDTH-1:0] o_head,
    output logic             o_not_empty
);

    logic [WIDTH-1:0] r_mem [FETCH_QDEPTH];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic             w_pop;

    assign o_not_empty = (r_count != 2'd0);
    assign w_pop       = i_pop & o_not_empty;
    assign o_count     = r_count;
    assign o_head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(i_push) - 2'(w_pop);
        end
    end

    // The fetch credit scheme must never let a push land on a full queue.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && i_push && !i_flush && !w_pop) begin
            assert (r_count < 2'(FETCH_QDEPTH));
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Sequential instruction fetcher with redirect and 2-deep queue.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import k423_if_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  fetch_en_i,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  if_valid_o,
    input  logic                  if_ready_i,
    output logic [DATA_WIDTH-1:0] if_inst_o,
    output logic [ADDR_WIDTH-1:0] if_pc_o
);

    localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ~ADDR_WIDTH'(INST_BYTES - 1);

    logic [ADDR_WIDTH-1:0]            r_pc;
    logic                             r_inflight;
    logic [ADDR_WIDTH-1:0]            r_inflight_pc;
    logic [1:0]                       w_count;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] w_head;
    logic                             w_pop;
    logic                             w_push;
    logic                             w_credit;

    assign w_pop    = if_valid_o & if_ready_i;
    assign w_credit = (3'(w_count) + 3'(r_inflight)) < 3'(FETCH_QDEPTH);
    assign w_push   = r_inflight & ~redirect_i;

    // Reset gates issue directly so the request drops the moment reset asserts.
    assign mem_en_o    = rst_n_i & fetch_en_i & ~redirect_i & (w_credit | w_pop);
    assign mem_we_o    = 1'b0;
    assign mem_wdata_o = '0;
    assign mem_addr_o  = r_pc;

    assign {if_pc_o, if_inst_o} = w_head;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_i) begin
            r_pc       <= redirect_pc_i & c_ALIGN_MASK;
            r_inflight <= 1'b0;
        end else if (mem_en_o) begin
            r_pc          <= r_pc + ADDR_WIDTH'(INST_BYTES);
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    fetch_queue #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_flush     (redirect_i),
        .i_data      ({r_inflight_pc, mem_rdata_i}),
        .o_count     (w_count),
        .o_head      (w_head),
        .o_not_empty (if_valid_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Scoreboard bench for inst_fetch with a sequential-stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;
    import k423_if_pkg::*;

    logic        clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_n, fetch_en, redirect, ready;
    logic [31:0] redirect_pc;
    logic        mem_en, mem_we, valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, inst, pc;

    logic        wr_mem_en, wr_mem_we, wr_valid;
    logic [31:0] wr_mem_addr, wr_mem_wdata, wr_mem_rdata, wr_inst, wr_pc;

    inst_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n), .fetch_en_i(fetch_en),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .if_valid_o(valid), .if_ready_i(ready), .if_inst_o(inst), .if_pc_o(pc)
    );

    inst_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk_i(clk_i), .rst_n_i(rst_n), .fetch_en_i(1'b1),
        .mem_en_o(wr_mem_en), .mem_we_o(wr_mem_we), .mem_addr_o(wr_mem_addr),
        .mem_wdata_o(wr_mem_wdata), .mem_rdata_i(wr_mem_rdata),
        .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .if_valid_o(wr_valid), .if_ready_i(1'b1), .if_inst_o(wr_inst), .if_pc_o(wr_pc)
    );

    // Memory holds word k at byte address 4k; idle cycles return garbage.
    always @(posedge clk_i) begin
        mem_rdata    <= mem_en    ? (mem_addr >> 2)    : $urandom();
        wr_mem_rdata <= wr_mem_en ? (wr_mem_addr >> 2) : $urandom();
    end

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected delivery stream: consecutive words from the last restart address.
    fetch_entry_t exp_q[$];
    logic [31:0]  fill_pc;
    fetch_entry_t mon_e;

    function automatic void topup();
        fetch_entry_t e;
        while (exp_q.size() < 8) begin
            e.pc   = fill_pc;
            e.inst = fill_pc >> 2;
            exp_q.push_back(e);
            fill_pc = fill_pc + 32'd4;
        end
    endfunction

    task automatic restart(input logic [31:0] a);
        exp_q.delete();
        fill_pc = {a[31:2], 2'b00};
        topup();
    endtask

    always @(negedge clk_i) begin
        if (rst_n && valid && ready && !redirect) begin
            topup();
            mon_e = exp_q.pop_front();
            check("pop_pc", pc, mon_e.pc);
            check("pop_inst", inst, mon_e.inst);
            n_pops++;
        end
    end

    logic [31:0] wrap_exp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    int widx;
    always @(negedge clk_i) begin
        if (!rst_n) begin
            widx = 0;
        end else if (wr_valid && widx < 3) begin
            check("wrap_pc", wr_pc, wrap_exp[widx]);
            check("wrap_inst", wr_inst, wrap_exp[widx] >> 2);
            widx++;
        end
    end

    task automatic wait_valid(input string name);
        int c;
        c = 0;
        while (!valid && c < 6) begin
            @(negedge clk_i);
            c++;
        end
        check(name, {31'd0, valid}, 32'd1);
    endtask

    int issues;

    initial begin
        rst_n = 1'b0; fetch_en = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        restart(32'h0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_we_wdata", {mem_wdata[30:0], mem_we}, 32'd0);
        check("rst_wrap_en", {31'd0, wr_mem_en}, 32'd0);

        // Streaming from reset with decode always ready.
        @(posedge clk_i); #1 rst_n = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk_i);
            if (c < 3) begin
                check("seq_en", {31'd0, mem_en}, 32'd1);
                check("seq_addr", mem_addr, 32'(c * 4));
            end
            check("seq_valid", {31'd0, valid}, (c >= 2) ? 32'd1 : 32'd0);
        end

        // Stall right after first valid: two fetches then no more issue.
        @(posedge clk_i); #1 rst_n = 1'b0; ready = 1'b0; restart(32'h0);
        @(posedge clk_i); #1 rst_n = 1'b1;
        issues = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (mem_en) issues++;
            if (valid) break;
        end
        for (int c = 0; c < 5; c++) begin
            check("stall_en", {31'd0, mem_en}, 32'd0);
            check("stall_head", pc, 32'h0);
            if (mem_en) issues++;
            @(negedge clk_i);
        end
        check("stall_issues", 32'(issues), 32'd2);
        @(posedge clk_i); #1 ready = 1'b1;
        repeat (6) @(posedge clk_i);
        #1 ready = 1'b0;
        repeat (4) @(posedge clk_i);

        // Redirect while the queue is full.
        #1 redirect = 1'b1; redirect_pc = 32'h100; restart(32'h100);
        @(negedge clk_i);
        check("redir_en_low", {31'd0, mem_en}, 32'd0);
        @(posedge clk_i); #1 redirect = 1'b0; ready = 1'b1;
        @(negedge clk_i);
        check("redir_en", {31'd0, mem_en}, 32'd1);
        check("redir_addr", mem_addr, 32'h100);
        wait_valid("redir_valid");
        check("redir_first_pc", pc, 32'h100);

        // Misaligned target, then back-to-back redirects.
        @(posedge clk_i); #1 redirect = 1'b1; redirect_pc = 32'h103; restart(32'h103);
        @(posedge clk_i); #1 redirect = 1'b0;
        @(negedge clk_i);
        check("align_addr", mem_addr, 32'h100);
        @(posedge clk_i); #1 redirect = 1'b1; redirect_pc = 32'h200; restart(32'h200);
        @(posedge clk_i); #1 redirect_pc = 32'h300; restart(32'h300);
        @(posedge clk_i); #1 redirect = 1'b0;
        @(negedge clk_i);
        check("b2b_addr", mem_addr, 32'h300);
        wait_valid("b2b_valid");
        check("b2b_first_pc", pc, 32'h300);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_i); #1;
            fetch_en = ($urandom % 5) != 0;
            ready    = ($urandom % 10) < 7;
            if (($urandom % 32) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
                restart(redirect_pc);
            end else begin
                redirect = 1'b0;
            end
        end
        @(posedge clk_i); #1 redirect = 1'b0; fetch_en = 1'b1; ready = 1'b0;
        repeat (4) @(posedge clk_i);
        check("pops_seen", {31'd0, n_pops > 1000}, 32'd1);

        // Asynchronous reset in the middle of operation.
        #2 rst_n = 1'b0; restart(32'h0);
        #1;
        check("arst_en", {31'd0, mem_en}, 32'd0);
        check("arst_valid", {31'd0, valid}, 32'd0);
        check("arst_wrap_valid", {31'd0, wr_valid}, 32'd0);
        @(posedge clk_i); #1 rst_n = 1'b1; ready = 1'b1;
        @(negedge clk_i);
        check("arst_restart_addr", mem_addr, 32'h0);
        wait_valid("arst_valid_again");
        check("arst_first_pc", pc, 32'h0);
        repeat (10) @(posedge clk_i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
